// File: rtl/ghr_checkpoint_manager.sv
// Speculative/architectural global history registers with an in-order checkpoint
// ring that restores speculative history on misprediction repair or flush.
module ghr_checkpoint_manager #(
  parameter int HIS_LEN    = 4,
  parameter int CKPT_DEPTH = 8,
  parameter int TAG_W      = $clog2(CKPT_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pred_valid_i,
  input  logic               pred_taken_i,
  output logic               pred_ready_o,
  output logic [TAG_W-1:0]   pred_tag_o,
  output logic [HIS_LEN-1:0] pred_ckpt_o,
  input  logic               repair_valid_i,
  input  logic [TAG_W-1:0]   repair_tag_i,
  input  logic               repair_taken_i,
  input  logic               commit_valid_i,
  input  logic               commit_taken_i,
  input  logic               flush_i,
  output logic [HIS_LEN-1:0] ghr_spec_o,
  output logic [HIS_LEN-1:0] ghr_arch_o,
  output logic [TAG_W:0]     ckpt_count_o
);

  localparam int PTR_W = TAG_W + 1;

  logic [HIS_LEN-1:0] spec_q, spec_d;
  logic [HIS_LEN-1:0] arch_q, arch_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [PTR_W-1:0]   count;
  logic [TAG_W-1:0]   rep_off;
  logic               full, empty, commit_fire, accept, repair_ok;

  logic [HIS_LEN-1:0] ckpt_q [CKPT_DEPTH];

  function automatic logic [HIS_LEN-1:0] shift_in(input logic [HIS_LEN-1:0] g,
                                                  input logic b);
    return {g[HIS_LEN-2:0], b};
  endfunction

  always_comb begin
    count       = tail_q - head_q;
    empty       = (count == '0);
    full        = (count == PTR_W'(CKPT_DEPTH));
    commit_fire = commit_valid_i && !empty;
    // Distance of the repaired tag from head; only tags currently in flight are honoured.
    rep_off     = repair_tag_i - head_q[TAG_W-1:0];
    repair_ok   = repair_valid_i && ({1'b0, rep_off} < count);
    accept      = pred_valid_i && !full && !flush_i && !repair_valid_i;

    head_d = head_q + PTR_W'(commit_fire);
    arch_d = commit_fire ? shift_in(arch_q, commit_taken_i) : arch_q;

    spec_d = spec_q;
    tail_d = tail_q;
    if (flush_i) begin
      spec_d = arch_d;
      tail_d = head_d;
    end else if (repair_ok) begin
      // Rebuilding tail from head keeps the wrap bit consistent across wrap-around.
      spec_d = shift_in(ckpt_q[repair_tag_i], repair_taken_i);
      tail_d = head_q + PTR_W'(rep_off) + PTR_W'(1);
    end else if (accept) begin
      spec_d = shift_in(spec_q, pred_taken_i);
      tail_d = tail_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_q <= '0;
      arch_q <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      spec_q <= spec_d;
      arch_q <= arch_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) ckpt_q[tail_q[TAG_W-1:0]] <= spec_q;
  end

  assign pred_ready_o = !full;
  assign pred_tag_o   = tail_q[TAG_W-1:0];
  assign pred_ckpt_o  = spec_q;
  assign ghr_spec_o   = spec_q;
  assign ghr_arch_o   = arch_q;
  assign ckpt_count_o = count;

  // Retiring with nothing in flight is a back-end protocol violation.
  assert property (@(posedge clk) disable iff (!rst) !(commit_valid_i && empty));

endmodule

// File: doc/ghr_checkpoint_manager.md
Name: ghr_checkpoint_manager

Overview:
- Owns the speculative and architectural global history registers (GHR) that index the global history table and the indirect-jump target cache.
- Shifts in each front-end branch prediction and allocates an in-order checkpoint recording the pre-update GHR.
- Restores history on back-end misprediction repair or pipeline flush, and retires checkpoints at commit.
- Sits upstream of the history table: its ghr_spec_o drives the table's read index, and its checkpoint tag travels down the pipe with the branch.

Parameters:
- HIS_LEN, 4, GHR width in bits.
- CKPT_DEPTH, 8, checkpoint entries (in-flight branches); power of two, at least 2.
- TAG_W, $clog2(CKPT_DEPTH), checkpoint tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- pred_valid_i  in  1  front end presents one predicted branch.
- pred_taken_i  in  1  predicted direction.
- pred_ready_o  out  1  checkpoint slot available.
- pred_tag_o  out  TAG_W  tag allocated to the accepted prediction; valid in the same cycle.
- pred_ckpt_o  out  HIS_LEN  GHR value before this prediction; stored with the branch.
- repair_valid_i  in  1  back end detected a direction misprediction.
- repair_tag_i  in  TAG_W  tag of the mispredicted branch.
- repair_taken_i  in  1  correct direction.
- commit_valid_i  in  1  oldest in-flight branch retires.
- commit_taken_i  in  1  its resolved direction.
- flush_i  in  1  exception/eret flush; discards all speculation.
- ghr_spec_o  out  HIS_LEN  speculative GHR.
- ghr_arch_o  out  HIS_LEN  committed GHR.
- ckpt_count_o  out  TAG_W+1  occupied entries.

Interface:
- One clock; reset is asynchronous and active-low.
- clk is the clock; rst is the active-low asynchronous reset.

Behaviour:
- Reset (rst=0, asynchronous):
  - ghr_spec, ghr_arch, head and tail pointers (TAG_W+1 bits, including the wrap bit), and the count are all cleared to 0.
  - pred_ready_o=1.
  - Checkpoint RAM contents are don't-care.
- Shift rule: next = {ghr[HIS_LEN-2:0], bit}. The newest outcome sits in the LSB.
- Accept: an accept occurs when pred_valid_i && pred_ready_o && !flush_i && !repair_valid_i.
  - pred_tag_o = tail[TAG_W-1:0] and pred_ckpt_o = ghr_spec, both combinational.
  - On the clock edge: ckpt[tail] <= ghr_spec; ghr_spec <= shift(ghr_spec, pred_taken_i); tail increments.
  - The new ghr_spec_o is visible the next cycle, i.e. one-cycle latency to the table index.
- pred_ready_o = !full, where full is (head/tail index equal and wrap bits differ). It is a pure pointer function and does not depend on pred_valid_i.
- Commit: when commit_valid_i and the structure is not empty:
  - ghr_arch <= shift(ghr_arch, commit_taken_i); head increments.
  - Commit while empty is a protocol error: ignored, with an assertion in simulation.
- Repair (repair_valid_i, tag between head and tail-1):
  - ghr_spec <= shift(ckpt[repair_tag_i], repair_taken_i).
  - tail <= repair_tag_i+1, carrying the wrap bit consistent with head. The repaired branch stays allocated and all younger entries are squashed.
  - A prediction in the same cycle is dropped; pred_ready_o is still reported, but no accept occurs.
- Flush: ghr_spec <= next value of ghr_arch (including a same-cycle commit); tail <= next head; the count becomes 0.
- Priority: flush > repair > accept. Commit is independent and applies in the same cycle as any of them.
- Simultaneous commit and repair of the same tag (head): the entry retires, and the new tail = head+1 = new head, so the structure becomes empty. The count must reach 0 with no underflow.
- Simultaneous accept and commit when full: accept is blocked (ready=0 that cycle); the commit proceeds.
- Pointer wrap: the index wraps modulo CKPT_DEPTH and the wrap bit toggles. The count is tail-head in TAG_W+1-bit arithmetic.
- Checkpoint RAM has one write port (accept) and one asynchronous read port (repair).

Test Plan:
- After reset, accept taken, taken, not-taken → pred_tag_o 0,1,2; pred_ckpt_o 0000,0001,0011; ghr_spec_o ends at 0110; count 3.
- Accept 8 predictions with no commits → pred_ready_o=0 after the 8th; a 9th pred_valid is ignored; a commit in the next cycle restores ready=1 and count=7.
- From GHR 0110 with tags 0..2 outstanding, repair tag 1 with taken=0 (ckpt[1]=0001) → ghr_spec_o=0010, count=2, next pred_tag_o=2.
- Repair, pred_valid and commit in the same cycle with head=tag=0 and 3 entries → prediction dropped, count=0, ghr_arch shifted once.
- Flush with ghr_arch=1010 and 5 outstanding entries → ghr_spec_o=1010, count=0, pred_tag_o equals the old head; issue 20 accept/commit pairs to check pointer wrap stays consistent.
- Assert rst low mid-repair (asynchronously, between edges) → all outputs return to 0 immediately and pred_ready_o=1.
